// File: rtl/vga_stream_controller_if.sv
// Frame-buffer read port between the VGA stream controller
// and the pixel memory: request out, data/valid back.
interface vga_stream_controller_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_dv;

  modport master (
    output r_en,
    output r_addr,
    input  r_data,
    input  r_dv
  );

  modport slave (
    input  r_en,
    input  r_addr,
    output r_data,
    output r_dv
  );
endinterface

// File: rtl/vga_stream_controller.sv
// VGA raster timing with frame-buffer fetch; sync, de, RGB and
// coordinates leave aligned after the read-latency delay line.
module vga_stream_controller #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIXEL_BITS = 4,
  parameter int RD_LATENCY = 1,
  localparam int H_BLANK = H_FP + H_SYNC + H_BP,
  localparam int H_TOTAL = H_BLANK + H_ACTIVE,
  localparam int V_BLANK = V_FP + V_SYNC + V_BP,
  localparam int V_TOTAL = V_BLANK + V_ACTIVE,
  localparam int ADDR_W  = $clog2(H_ACTIVE * V_ACTIVE),
  localparam int X_W     = $clog2(H_ACTIVE),
  localparam int Y_W     = $clog2(V_ACTIVE)
) (
  input  logic                  pclk,
  input  logic                  rst,
  vga_stream_controller_if.master fb,
  output logic [PIXEL_BITS-1:0] red_bits,
  output logic [PIXEL_BITS-1:0] green_bits,
  output logic [PIXEL_BITS-1:0] blue_bits,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [X_W-1:0]        pixel_x,
  output logic [Y_W-1:0]        pixel_y,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int CW = $clog2(H_TOTAL);
  localparam int LW = $clog2(V_TOTAL);
  localparam int DW = 3 * PIXEL_BITS;

  localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] COL_ACT  = CW'(H_BLANK);
  localparam logic [CW-1:0] COL_HS0  = CW'(H_FP);
  localparam logic [CW-1:0] COL_HS1  = CW'(H_FP + H_SYNC);

  localparam logic [LW-1:0] LINE_LAST = LW'(V_TOTAL - 1);
  localparam logic [LW-1:0] LINE_ACT  = LW'(V_BLANK);
  localparam logic [LW-1:0] LINE_VS0  = LW'(V_FP);
  localparam logic [LW-1:0] LINE_VS1  = LW'(V_FP + V_SYNC);

  if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
    $error("RD_LATENCY must be in 1..8");
  end

  typedef struct packed {
    logic           hs;
    logic           vs;
    logic           act;
    logic           first;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } tap_t;

  localparam tap_t TAP_IDLE = '{
    hs:    ~HSYNC_POL,
    vs:    ~VSYNC_POL,
    act:   1'b0,
    first: 1'b0,
    x:     '0,
    y:     '0
  };

  logic [CW-1:0]     col;
  logic [LW-1:0]     line;
  logic [ADDR_W-1:0] addr_q;
  logic              col_wrap;
  logic              line_wrap;
  logic              h_act;
  logic              v_act;
  logic              active0;
  tap_t              tap0;
  tap_t              pipe [RD_LATENCY];
  tap_t              tail;
  logic [DW-1:0]     rgb_q;

  assign col_wrap  = (col == COL_LAST);
  assign line_wrap = (line == LINE_LAST);
  assign h_act     = (col >= COL_ACT);
  assign v_act     = (line >= LINE_ACT);
  assign active0   = h_act && v_act;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      line <= '0;
    end else if (col_wrap) begin
      col  <= '0;
      line <= line_wrap ? '0 : line + LW'(1);
    end else begin
      col <= col + CW'(1);
    end
  end

  // Row-major address tracks the raster, so no multiplier is needed.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (col_wrap && line_wrap) begin
      addr_q <= '0;
    end else if (active0) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign fb.r_en   = active0;
  assign fb.r_addr = addr_q;

  always_comb begin
    tap0       = '0;
    tap0.hs    = (col >= COL_HS0 && col < COL_HS1)
               ? HSYNC_POL : ~HSYNC_POL;
    tap0.vs    = (line >= LINE_VS0 && line < LINE_VS1)
               ? VSYNC_POL : ~VSYNC_POL;
    tap0.act   = active0;
    tap0.first = (col == COL_ACT) && (line == LINE_ACT);
    if (active0) begin
      tap0.x = X_W'(col - COL_ACT);
      tap0.y = Y_W'(line - LINE_ACT);
    end
  end

  // Delay matches the read latency; the output register adds one more.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe[i] <= TAP_IDLE;
      end
    end else begin
      pipe[0] <= tap0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[RD_LATENCY-1];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      rgb_q       <= (tail.act && fb.r_dv) ? fb.r_data : '0;
      hsync       <= tail.hs;
      vsync       <= tail.vs;
      de          <= tail.act;
      pixel_x     <= tail.x;
      pixel_y     <= tail.y;
      frame_start <= tail.first;
    end
  end

  // A miss on the first pixel must survive its own frame-start clear.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (tail.act && !fb.r_dv) begin
      underflow <= 1'b1;
    end else if (tail.first) begin
      underflow <= 1'b0;
    end
  end

  assign red_bits   = rgb_q[DW-1 -: PIXEL_BITS];
  assign green_bits = rgb_q[2*PIXEL_BITS-1 -: PIXEL_BITS];
  assign blue_bits  = rgb_q[PIXEL_BITS-1:0];

endmodule

// File: tb/tb_vga_stream_controller.sv
// Bench for vga_stream_controller: two instances (latency 2 / low
// syncs and latency 1 / high syncs) against an arithmetic raster model.
module tb_vga_stream_controller;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int HB = 6;
  localparam int VB = 3;
  localparam int HA = 8;
  localparam int FR = HT * VT;

  typedef struct packed {
    logic        de;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [2:0]  x;
    logic [1:0]  y;
    logic        fs;
    logic        uf;
  } out_t;

  typedef struct packed {
    logic       en;
    logic       chk;
    logic [4:0] addr;
  } rd_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  int  mode      = 0;
  bit  drop_en   = 1'b0;
  int  drop_addr = 0;
  logic [11:0] mem [32];
  int  n_checks = 0;
  int  n_pass   = 0;

  vga_stream_controller_if #(.ADDR_W(5), .DATA_W(12)) fb_a ();
  vga_stream_controller_if #(.ADDR_W(5), .DATA_W(12)) fb_b ();

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, de_a, fs_a, uf_a;
  logic       hs_b, vs_b, de_b, fs_b, uf_b;
  logic [2:0] x_a, x_b;
  logic [1:0] y_a, y_b;

  vga_stream_controller #(
    .H_ACTIVE(8), .V_ACTIVE(4),
    .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .PIXEL_BITS(4), .RD_LATENCY(2)
  ) dut_a (
    .pclk(pclk), .rst(rst), .fb(fb_a.master),
    .red_bits(r_a), .green_bits(g_a), .blue_bits(b_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .pixel_x(x_a), .pixel_y(y_a),
    .frame_start(fs_a), .underflow(uf_a)
  );

  vga_stream_controller #(
    .H_ACTIVE(8), .V_ACTIVE(4),
    .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .PIXEL_BITS(4), .RD_LATENCY(1)
  ) dut_b (
    .pclk(pclk), .rst(rst), .fb(fb_b.master),
    .red_bits(r_b), .green_bits(g_b), .blue_bits(b_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .pixel_x(x_b), .pixel_y(y_b),
    .frame_start(fs_b), .underflow(uf_b)
  );

  // Frame-buffer models; they ignore rst so in-flight reads still return.
  logic       ea0 = 1'b0, ea1 = 1'b0, eb0 = 1'b0;
  logic [4:0] aa0 = '0, aa1 = '0, ab0 = '0;

  always @(posedge pclk) begin
    ea0 <= fb_a.r_en;
    aa0 <= fb_a.r_addr;
    ea1 <= ea0;
    aa1 <= aa0;
    eb0 <= fb_b.r_en;
    ab0 <= fb_b.r_addr;
  end

  assign fb_a.r_data = (mode == 2) ? 12'hFFF : mem[aa1];
  assign fb_a.r_dv   = (mode == 2) ? 1'b1
                     : (ea1 && !(drop_en && int'(aa1) == drop_addr));
  assign fb_b.r_data = (mode == 2) ? 12'hFFF : mem[ab0];
  assign fb_b.r_dv   = (mode == 2) ? 1'b1
                     : (eb0 && !(drop_en && int'(ab0) == drop_addr));

  function automatic out_t obs_a();
    out_t o;
    o.de = de_a; o.rgb = {r_a, g_a, b_a};
    o.hs = hs_a; o.vs = vs_a;
    o.x = x_a; o.y = y_a;
    o.fs = fs_a; o.uf = uf_a;
    return o;
  endfunction

  function automatic out_t obs_b();
    out_t o;
    o.de = de_b; o.rgb = {r_b, g_b, b_b};
    o.hs = hs_b; o.vs = vs_b;
    o.x = x_b; o.y = y_b;
    o.fs = fs_b; o.uf = uf_b;
    return o;
  endfunction

  // Expected outputs k cycles after reset release, from raster arithmetic.
  function automatic out_t exp_out(int k, int lat, bit pol);
    out_t e;
    int s, col, line, a, f, o, pd;
    e    = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    s    = k - lat - 1;
    if (s < 0) return e;
    col  = s % HT;
    line = (s / HT) % VT;
    f    = s / FR;
    o    = s % FR;
    e.hs = (col >= 2 && col < 4) ? pol : ~pol;
    e.vs = (line == 1) ? pol : ~pol;
    if (col >= HB && line >= VB) begin
      a    = (line - VB) * HA + (col - HB);
      e.de = 1'b1;
      e.x  = 3'(col - HB);
      e.y  = 2'(line - VB);
      e.fs = (a == 0);
      if (mode == 2) e.rgb = 12'hFFF;
      else if (drop_en && a == drop_addr) e.rgb = '0;
      else e.rgb = mem[a];
    end
    if (drop_en) begin
      pd   = (VB + drop_addr / HA) * HT + HB + drop_addr % HA;
      e.uf = (o >= pd) || (f > 0 && o < VB * HT + HB);
    end
    return e;
  endfunction

  function automatic rd_t exp_rd(int k);
    rd_t r;
    int col, line;
    col   = k % HT;
    line  = (k / HT) % VT;
    r     = '0;
    r.en  = (col >= HB && line >= VB);
    r.chk = r.en || (col == 0 && line == 0);
    if (r.en) r.addr = 5'((line - VB) * HA + col - HB);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2 + $urandom_range(0, 3)) @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 32; i++) mem[i] = 12'(i);
  endtask

  task automatic test_reset();
    out_t ra, rb;
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    ra = exp_out(-1, 2, 1'b0);
    rb = exp_out(-1, 1, 1'b1);
    n_checks += 3;
    if (obs_a() !== ra)
      $display("FAIL reset_out_a got=%h want=%h", obs_a(), ra);
    else n_pass++;
    if (obs_b() !== rb)
      $display("FAIL reset_out_b got=%h want=%h", obs_b(), rb);
    else n_pass++;
    if (fb_a.r_en !== 1'b0 || fb_a.r_addr !== 5'd0)
      $display("FAIL reset_rd got=%b/%0d want=0/0",
               fb_a.r_en, fb_a.r_addr);
    else n_pass++;
  endtask

  task automatic test_raster();
    out_t ea, eb;
    rd_t  er;
    int en_cnt [2];
    int vs_low, vs_run, vs_best, fs_cnt, bad_addr, idx;
    en_cnt = '{0, 0};
    vs_low = 0; vs_run = 0; vs_best = 0;
    fs_cnt = 0; bad_addr = 0; idx = 0;
    mode = 0; drop_en = 1'b0;
    fill_identity();
    do_reset();
    for (int k = 0; k < 2 * FR + 3; k++) begin
      ea = exp_out(k, 2, 1'b0);
      eb = exp_out(k, 1, 1'b1);
      er = exp_rd(k);
      n_checks += 3;
      if (obs_a() !== ea)
        $display("FAIL raster_a k=%0d got=%h want=%h", k, obs_a(), ea);
      else n_pass++;
      if (obs_b() !== eb)
        $display("FAIL raster_b k=%0d got=%h want=%h", k, obs_b(), eb);
      else n_pass++;
      if (fb_a.r_en !== er.en || fb_b.r_en !== er.en ||
          (er.chk && (fb_a.r_addr !== er.addr ||
                      fb_b.r_addr !== er.addr)))
        $display("FAIL raster_rd k=%0d got=%b/%0d want=%b/%0d",
                 k, fb_a.r_en, fb_a.r_addr, er.en, er.addr);
      else n_pass++;
      if (k < 2 * FR && fb_a.r_en) en_cnt[k / FR]++;
      if (fb_a.r_en) begin
        if (int'(fb_a.r_addr) != idx % 32) bad_addr++;
        idx++;
      end
      if (k >= 3 && k < 3 + FR) begin
        if (!vs_a) begin
          vs_low++;
          vs_run++;
          if (vs_run > vs_best) vs_best = vs_run;
        end else vs_run = 0;
      end
      if (fs_a) fs_cnt++;
      @(negedge pclk);
    end
    n_checks += 5;
    if (en_cnt[0] != 32 || en_cnt[1] != 32)
      $display("FAIL ren_count got=%0d,%0d want=32,32",
               en_cnt[0], en_cnt[1]);
    else n_pass++;
    if (bad_addr != 0 || idx != 64)
      $display("FAIL addr_seq got=%0d bad/%0d reqs want=0/64",
               bad_addr, idx);
    else n_pass++;
    if (vs_low != 14)
      $display("FAIL vsync_low got=%0d want=14", vs_low);
    else n_pass++;
    if (vs_best != 14)
      $display("FAIL vsync_run got=%0d want=14", vs_best);
    else n_pass++;
    if (fs_cnt != 2)
      $display("FAIL frame_start_count got=%0d want=2", fs_cnt);
    else n_pass++;
  endtask

  task automatic test_underflow();
    out_t ea, eb;
    int saw;
    saw = 0;
    mode = 0; drop_en = 1'b1; drop_addr = 13;
    fill_identity();
    do_reset();
    for (int k = 0; k < 2 * FR + 10; k++) begin
      ea = exp_out(k, 2, 1'b0);
      eb = exp_out(k, 1, 1'b1);
      n_checks += 2;
      if (obs_a() !== ea)
        $display("FAIL uflow_a k=%0d got=%h want=%h", k, obs_a(), ea);
      else n_pass++;
      if (obs_b() !== eb)
        $display("FAIL uflow_b k=%0d got=%h want=%h", k, obs_b(), eb);
      else n_pass++;
      if (de_a === 1'b1 && x_a === 3'd5 && y_a === 2'd1) begin
        saw++;
        n_checks++;
        if ({r_a, g_a, b_a} !== 12'h000 || uf_a !== 1'b1)
          $display("FAIL uflow_px k=%0d got=%h/%b want=000/1",
                   k, {r_a, g_a, b_a}, uf_a);
        else n_pass++;
      end
      @(negedge pclk);
    end
    n_checks++;
    if (saw != 2)
      $display("FAIL uflow_seen got=%0d want=2", saw);
    else n_pass++;
    drop_en = 1'b0;
  endtask

  task automatic test_blanking();
    out_t ea, eb;
    int nz;
    nz = 0;
    mode = 2; drop_en = 1'b0;
    do_reset();
    for (int k = 0; k < FR + 4; k++) begin
      ea = exp_out(k, 2, 1'b0);
      eb = exp_out(k, 1, 1'b1);
      n_checks += 2;
      if (obs_a() !== ea)
        $display("FAIL blank_a k=%0d got=%h want=%h", k, obs_a(), ea);
      else n_pass++;
      if (obs_b() !== eb)
        $display("FAIL blank_b k=%0d got=%h want=%h", k, obs_b(), eb);
      else n_pass++;
      if (!de_a && {r_a, g_a, b_a} != 12'h000) nz++;
      if (!de_b && {r_b, g_b, b_b} != 12'h000) nz++;
      @(negedge pclk);
    end
    n_checks++;
    if (nz != 0)
      $display("FAIL blank_rgb got=%0d nonzero want=0", nz);
    else n_pass++;
    mode = 0;
  endtask

  task automatic test_async_reset();
    out_t ea, eb, ra, rb;
    rd_t  er;
    mode = 0; drop_en = 1'b0;
    fill_identity();
    do_reset();
    for (int k = 0; k < 4 * HT + 9; k++) @(negedge pclk);
    #2 rst = 1'b1;
    #1;
    ra = exp_out(-1, 2, 1'b0);
    rb = exp_out(-1, 1, 1'b1);
    n_checks += 3;
    if (obs_a() !== ra)
      $display("FAIL async_out_a got=%h want=%h", obs_a(), ra);
    else n_pass++;
    if (obs_b() !== rb)
      $display("FAIL async_out_b got=%h want=%h", obs_b(), rb);
    else n_pass++;
    if (fb_a.r_en !== 1'b0 || fb_a.r_addr !== 5'd0)
      $display("FAIL async_rd got=%b/%0d want=0/0",
               fb_a.r_en, fb_a.r_addr);
    else n_pass++;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    for (int k = 0; k < FR + 4; k++) begin
      ea = exp_out(k, 2, 1'b0);
      eb = exp_out(k, 1, 1'b1);
      er = exp_rd(k);
      n_checks += 3;
      if (obs_a() !== ea)
        $display("FAIL rerun_a k=%0d got=%h want=%h", k, obs_a(), ea);
      else n_pass++;
      if (obs_b() !== eb)
        $display("FAIL rerun_b k=%0d got=%h want=%h", k, obs_b(), eb);
      else n_pass++;
      if (fb_a.r_en !== er.en ||
          (er.chk && fb_a.r_addr !== er.addr))
        $display("FAIL rerun_rd k=%0d got=%b/%0d want=%b/%0d",
                 k, fb_a.r_en, fb_a.r_addr, er.en, er.addr);
      else n_pass++;
      @(negedge pclk);
    end
  endtask

  task automatic test_random();
    out_t ea, eb;
    mode = 0;
    for (int i = 0; i < 32; i++) mem[i] = 12'($urandom);
    drop_en   = 1'b1;
    drop_addr = int'($urandom_range(0, 31));
    do_reset();
    for (int k = 0; k < 2 * FR + 10; k++) begin
      ea = exp_out(k, 2, 1'b0);
      eb = exp_out(k, 1, 1'b1);
      n_checks += 2;
      if (obs_a() !== ea)
        $display("FAIL rand_a k=%0d drop=%0d got=%h want=%h",
                 k, drop_addr, obs_a(), ea);
      else n_pass++;
      if (obs_b() !== eb)
        $display("FAIL rand_b k=%0d drop=%0d got=%h want=%h",
                 k, drop_addr, obs_b(), eb);
      else n_pass++;
      @(negedge pclk);
    end
    drop_en = 1'b0;
  endtask

  initial begin
    fill_identity();
    test_reset();
    test_raster();
    test_underflow();
    test_blanking();
    test_async_reset();
    test_random();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_stream_controller.md
# vga_stream_controller

Parametrised VGA timing and pixel-fetch controller, the next generation of the fixed 12-bit VGA controller. Generates the raster counters and sync pulses, issues frame-buffer reads only during the active region, and compensates for a configurable read latency. RGB, sync, data-enable and pixel coordinates leave the block mutually aligned. It sits between the frame buffer read port and the VGA DAC pins, in the pixel-clock domain.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (pixels)
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (lines)
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted level of hsync / vsync
- PIXEL_BITS, 4, bits per colour channel
- RD_LATENCY, 1, cycles from r_en to r_data/r_dv (range 1..8)
- Derived: H_BLANK=H_FP+H_SYNC+H_BP; H_TOTAL=H_BLANK+H_ACTIVE; V_BLANK and V_TOTAL likewise; ADDR_W=$clog2(H_ACTIVE*V_ACTIVE); X_W=$clog2(H_ACTIVE); Y_W=$clog2(V_ACTIVE)

Ports:
- pclk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- r_en  out  1  read request to frame buffer
- r_addr  out  ADDR_W  read address, row-major
- r_data  in  3*PIXEL_BITS  read data {R,G,B}, R in MSBs
- r_dv  in  1  r_data valid, RD_LATENCY cycles after r_en
- red_bits / green_bits / blue_bits  out  PIXEL_BITS each  colour outputs
- hsync / vsync  out  1  sync outputs
- de  out  1  active-video flag, aligned with RGB
- pixel_x / pixel_y  out  X_W / Y_W  coordinates of the pixel currently on the RGB outputs; 0 when de=0
- frame_start  out  1  one-cycle pulse with output pixel (0,0)
- underflow  out  1  sticky: an active pixel arrived without r_dv

## Operation
- Stage 0: counters. col runs 0..H_TOTAL-1 and wraps. At the wrap, line increments and wraps at V_TOTAL-1.
- Region order per line: front porch, sync, back porch, active. Active columns are [H_BLANK, H_TOTAL) and active lines are [V_BLANK, V_TOTAL).
- hsync0 is asserted (=HSYNC_POL) for col in [H_FP, H_FP+H_SYNC). vsync0 is asserted for line in [V_FP, V_FP+V_SYNC) over whole lines.
- r_en is a combinational view of stage 0: r_en=1 exactly when col and line are both active.
- r_addr = (line-V_BLANK)*H_ACTIVE + (col-H_BLANK) when r_en=1. It is implemented as an incrementing counter, with no multiplier.
  - The counter increments on every r_en cycle.
  - It clears to 0 when line=0, col=0.
  - Between requests, r_addr holds its last value.
- A delay line of RD_LATENCY+1 registers carries {hsync0, vsync0, active0, x0, y0, first0}. first0 = (col==H_BLANK && line==V_BLANK).
- Output register, loaded every cycle from the delay-line tail and from r_data/r_dv:
  - If de_tail=1 and r_dv=1: RGB = r_data.
  - If de_tail=1 and r_dv=0: RGB = 0 and underflow is set.
  - If de_tail=0: RGB = 0. r_dv is ignored.
- underflow clears on the cycle frame_start asserts. If that same pixel also underflows, the set wins.
- The block has no stall path; raster timing never pauses.

## Timing
- Output latency: hsync, vsync, de, RGB, pixel_x, pixel_y and frame_start are all RD_LATENCY+1 cycles behind stage 0. They are mutually aligned in the same cycle.
- r_en and r_addr have 0 cycles of latency from stage 0.
- Frame period is H_TOTAL*V_TOTAL cycles; the line period is H_TOTAL cycles.
- Reset value of every output:
  - r_en=0, r_addr=0, RGB=0, de=0, pixel_x=0, pixel_y=0, frame_start=0, underflow=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - Counters=0 and all delay-line entries inactive.
- Reset mid-frame: the raster restarts at col=0, line=0 on the first pclk edge after rst deasserts. Pipeline contents are discarded. Reads already in flight return while de_tail=0 and are ignored.
- The first frame after reset begins at stage-0 (0,0). The first frame_start occurs at cycle V_BLANK*H_TOTAL+H_BLANK+RD_LATENCY+1 after reset release.

## Test plan
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); RD_LATENCY=2; model memory returns data=address with r_dv=1.
- Reset release, run 2 frames:
  - r_en is high for exactly 32 cycles per 98-cycle frame.
  - r_addr runs 0..31 in order, then restarts at 0.
  - hsync is low for 2 of every 14 cycles; vsync is low for exactly 14 consecutive cycles per frame.
- Alignment: every cycle with de=1 has RGB == pixel_y*8+pixel_x. de rises exactly 3 cycles after r_en. frame_start fires exactly once per frame, with pixel_x=0 and pixel_y=0.
- Underflow: drop r_dv for address 13 only. Output pixel (5,1) is RGB=0 with de=1, and underflow=1 from that cycle onward. underflow clears at the next frame_start.
- Blanking data: drive r_data=12'hFFF with r_dv=1 continuously. RGB stays 0 whenever de=0.
- Async reset: assert rst mid-line at line 4, col 9. All outputs take their reset values immediately, without waiting for a pclk edge. After release, the raster timing matches the timing seen after the first reset.
- Polarity: HSYNC_POL=1, VSYNC_POL=1, RD_LATENCY=1. Syncs idle low and pulse high with the same widths, and the output latency becomes 2.
